conv_pool_sequencer: RTL and testbench

Sequencer for the layer-2 convolution / ReLU / max-pool datapath on one 4-channel feature stream.
- Accepts input samples over a valid/ready handshake.
- Drives the 5-tap window shift and zero-pad controls.
- Fires the conv engine once per window.
- Steers each ReLU result into one of POOL pooling slots, fires the pool engine, and hands each pooled result downstream with backpressure.
- Sits between the layer-1 output buffer and the layer-3 input, replacing ad hoc wait-count sequencing.

---
 rtl/conv_pool_sequencer_if.sv | 25 ++
 rtl/conv_pool_sequencer.sv | 150 +++++++++++++++
 tb/tb_conv_pool_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pool_sequencer_if.sv
// rtl/conv_pool_sequencer_if.sv - sample/result handshake and datapath control bundle
// master: sequencer side; slave: upstream/datapath/downstream side.
interface conv_pool_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic       win_shift;
   logic       win_zero;
   logic       conv_en;
   logic       relu_cap;
   logic [2:0] pool_slot;
   logic       pool_en;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] out_idx;

   modport master (
      input  in_valid, out_ready,
      output in_ready, win_shift, win_zero, conv_en, relu_cap, pool_slot, pool_en, out_valid, out_idx
   );

   modport slave (
      output in_valid, out_ready,
      input  in_ready, win_shift, win_zero, conv_en, relu_cap, pool_slot, pool_en, out_valid, out_idx
   );
endinterface

// File: rtl/conv_pool_sequencer.sv
// rtl/conv_pool_sequencer.sv - conv/ReLU/max-pool sequencer for one 4-channel feature frame
// Optional CONV_POOL_SEQ_PERF_EN adds the stall_cycles output-backpressure counter.
module conv_pool_sequencer #(
   parameter int TAPS    = 5,
   parameter int POOL    = 5,
   parameter int SEQ_LEN = 500,
   parameter int OUT_LEN = 100,
   parameter int CW      = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   conv_pool_sequencer_if.master  bus
`ifdef CONV_POOL_SEQ_PERF_EN
   ,
   output logic [15:0]            stall_cycles
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_PAD, S_DRAIN, S_DONE} state_t;

   state_t        r_state, w_next;
   logic [CW-1:0] r_smp;
   logic [CW-1:0] r_pad;
   logic [6:0]    r_out_idx;
   logic [2:0]    r_issue_slot;
   logic [2:0]    r_cap_slot;
   logic [2:0]    r_pool_slot;
   logic          r_conv_en;
   logic          r_relu_cap;
   logic          r_grp_issued;
   logic          r_grp_full;
   logic          r_out_valid;

   logic w_stall, w_in_ready, w_accept, w_pad_shift, w_shift, w_conv_shift;
   logic w_pool_en, w_out_acc, w_start_acc;

   // A fully issued group may not be shifted past while the previous result is still
   // unaccepted; blocking at issue time keeps its pool slots from being overwritten.
   assign w_stall      = r_grp_issued & r_out_valid & ~bus.out_ready;
   assign w_in_ready   = (r_state == S_FILL) | ((r_state == S_RUN) & ~w_stall);
   assign w_accept     = w_in_ready & bus.in_valid;
   assign w_pad_shift  = (r_state == S_PAD) & ~w_stall;
   assign w_shift      = w_accept | w_pad_shift;
   assign w_conv_shift = (w_accept & (r_state == S_RUN)) | w_pad_shift;
   assign w_pool_en    = r_grp_full & (~r_out_valid | bus.out_ready);
   assign w_out_acc    = r_out_valid & bus.out_ready;
   assign w_start_acc  = (r_state == S_IDLE) & start;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_FILL;
         S_FILL:  if (w_accept && r_smp == CW'(TAPS - 2)) w_next = S_RUN;
         S_RUN:   if (w_accept && r_smp == CW'(SEQ_LEN - 1)) w_next = S_PAD;
         S_PAD:   if (w_pad_shift && r_pad == CW'(TAPS - 2)) w_next = S_DRAIN;
         S_DRAIN: if (w_out_acc && r_out_idx == 7'(OUT_LEN - 1)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_smp        <= '0;
         r_pad        <= '0;
         r_out_idx    <= '0;
         r_issue_slot <= '0;
         r_cap_slot   <= '0;
         r_pool_slot  <= '0;
         r_conv_en    <= 1'b0;
         r_relu_cap   <= 1'b0;
         r_grp_issued <= 1'b0;
         r_grp_full   <= 1'b0;
         r_out_valid  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_start_acc) begin
            r_smp        <= '0;
            r_pad        <= '0;
            r_out_idx    <= '0;
            r_issue_slot <= '0;
            r_cap_slot   <= '0;
         end else begin
            if (w_accept)
               r_smp <= r_smp + 1'b1;
            if (w_pad_shift)
               r_pad <= r_pad + 1'b1;
            if (w_out_acc && r_out_idx != 7'(OUT_LEN - 1))
               r_out_idx <= r_out_idx + 7'd1;
            if (w_conv_shift)
               r_issue_slot <= (r_issue_slot == 3'(POOL - 1)) ? 3'd0 : r_issue_slot + 3'd1;
            if (r_conv_en)
               r_cap_slot <= (r_cap_slot == 3'(POOL - 1)) ? 3'd0 : r_cap_slot + 3'd1;
         end

         // shift -> conv_en -> relu_cap -> pool_en -> out_valid, one stage per cycle
         r_conv_en  <= w_conv_shift;
         r_relu_cap <= r_conv_en;
         if (r_conv_en)
            r_pool_slot <= r_cap_slot;

         if (w_conv_shift && r_issue_slot == 3'(POOL - 1))
            r_grp_issued <= 1'b1;
         else if (w_pool_en)
            r_grp_issued <= 1'b0;

         if (r_relu_cap && r_pool_slot == 3'(POOL - 1))
            r_grp_full <= 1'b1;
         else if (w_pool_en)
            r_grp_full <= 1'b0;

         if (w_pool_en)
            r_out_valid <= 1'b1;
         else if (bus.out_ready)
            r_out_valid <= 1'b0;
      end
   end

   assign busy          = (r_state != S_IDLE);
   assign done          = (r_state == S_DONE);
   assign bus.in_ready  = w_in_ready;
   assign bus.win_shift = w_shift;
   assign bus.win_zero  = w_pad_shift;
   assign bus.conv_en   = r_conv_en;
   assign bus.relu_cap  = r_relu_cap;
   assign bus.pool_slot = r_pool_slot;
   assign bus.pool_en   = w_pool_en;
   assign bus.out_valid = r_out_valid;
   assign bus.out_idx   = r_out_idx;

`ifdef CONV_POOL_SEQ_PERF_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (w_start_acc)
         r_stall_cnt <= '0;
      else if (r_out_valid && !bus.out_ready && r_stall_cnt != 16'hFFFF)
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv_pool_sequencer.sv
// tb/tb_conv_pool_sequencer.sv - directed self-checking bench for conv_pool_sequencer
module tb_conv_pool_sequencer;
   localparam int TAPS = 5;
   localparam int POOL = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, done;
`ifdef CONV_POOL_SEQ_PERF_EN
   logic [15:0] stall_cycles;
`endif

   conv_pool_sequencer_if bus ();

   conv_pool_sequencer dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
`ifdef CONV_POOL_SEQ_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   bit mon_clr = 1'b1;
   bit mon_strict = 1'b0;
   int n_acc, n_shift, n_conv, n_pool, n_out, n_done, n_zero, n_zero_bad, n_hold;
   int n_conv_err, n_cap_err, n_pool_err, n_ov_err, n_idx_err, first_conv_acc;
   logic exp_conv, exp_cap, exp_pool, prev_pool, prev_ov, prev_or;
   logic [2:0] exp_slot;
   logic [6:0] last_idx;

   // Reference pipeline model, sampled on the falling edge.
   always @(negedge clk) begin
      if (mon_clr) begin
         n_acc <= 0; n_shift <= 0; n_conv <= 0; n_pool <= 0; n_out <= 0; n_done <= 0;
         n_zero <= 0; n_zero_bad <= 0; n_hold <= 0; n_conv_err <= 0; n_cap_err <= 0;
         n_pool_err <= 0; n_ov_err <= 0; n_idx_err <= 0; first_conv_acc <= -1;
         exp_conv <= 1'b0; exp_cap <= 1'b0; exp_pool <= 1'b0; prev_pool <= 1'b0;
         prev_ov <= 1'b0; prev_or <= 1'b0; exp_slot <= '0; last_idx <= '0;
      end else begin
         if (bus.in_valid && bus.in_ready) n_acc <= n_acc + 1;
         if (bus.win_shift) n_shift <= n_shift + 1;
         exp_conv <= bus.win_shift && (n_shift >= TAPS - 1);
         if (bus.conv_en !== exp_conv) n_conv_err <= n_conv_err + 1;
         if (bus.conv_en) begin
            n_conv <= n_conv + 1;
            if (n_conv == 0) first_conv_acc <= n_acc;
         end
         exp_cap  <= bus.conv_en;
         exp_slot <= 3'(n_conv % POOL);
         if (bus.relu_cap !== exp_cap || (exp_cap && bus.pool_slot !== exp_slot))
            n_cap_err <= n_cap_err + 1;
         exp_pool <= bus.relu_cap && (bus.pool_slot == 3'(POOL - 1));
         if (mon_strict && bus.pool_en !== exp_pool) n_pool_err <= n_pool_err + 1;
         if (bus.pool_en) n_pool <= n_pool + 1;
         prev_pool <= bus.pool_en;
         prev_ov   <= bus.out_valid;
         prev_or   <= bus.out_ready;
         if ((prev_pool && !bus.out_valid) || (prev_ov && !prev_or && !bus.out_valid))
            n_ov_err <= n_ov_err + 1;
         if (bus.out_valid && bus.out_ready) begin
            if (bus.out_idx !== 7'(n_out)) n_idx_err <= n_idx_err + 1;
            n_out    <= n_out + 1;
            last_idx <= bus.out_idx;
         end
         if (bus.out_valid && !bus.out_ready) n_hold <= n_hold + 1;
         if (bus.win_zero) begin
            n_zero <= n_zero + 1;
            if (bus.in_ready || !bus.win_shift) n_zero_bad <= n_zero_bad + 1;
         end
         if (done) n_done <= n_done + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit toggle, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (toggle) bus.in_valid = ~bus.in_valid;
         if (n_done > 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [18:0] outs;
      rst = 1'b1;
      start = 1'b0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      mon_clr = 1'b1;
      repeat (3) tick();
      outs = {busy, done, bus.in_ready, bus.win_shift, bus.win_zero, bus.conv_en, bus.relu_cap,
              bus.pool_slot, bus.pool_en, bus.out_valid, bus.out_idx};
      checks++;
      if (outs !== 19'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
`ifdef CONV_POOL_SEQ_PERF_EN
      checks++;
      if (stall_cycles !== 16'd0) begin
         failures++;
         $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles);
      end
`endif
      rst = 1'b0;
      tick();
   endtask

   task automatic test_full_frame();
      bit ok;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      mon_strict = 1'b1;
      start_frame();
      wait_done(2000, 1'b0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL full_done_timeout: got no done expected done within 2000"); end
      repeat (2) tick();
      checks++;
      if (first_conv_acc !== 5) begin failures++; $display("FAIL first_conv_after_accept: got %0d expected 5", first_conv_acc); end
      checks++;
      if (n_acc !== 500) begin failures++; $display("FAIL full_accepts: got %0d expected 500", n_acc); end
      checks++;
      if (n_conv !== 500) begin failures++; $display("FAIL full_conv_en: got %0d expected 500", n_conv); end
      checks++;
      if (n_pool !== 100) begin failures++; $display("FAIL full_pool_en: got %0d expected 100", n_pool); end
      checks++;
      if (n_out !== 100 || last_idx !== 7'd99) begin failures++; $display("FAIL full_outputs: got %0d last %0d expected 100 last 99", n_out, last_idx); end
      checks++;
      if (n_done !== 1 || busy !== 1'b0) begin failures++; $display("FAIL full_done_busy: got done=%0d busy=%0b expected 1 0", n_done, busy); end
      checks++;
      if (n_zero !== 4 || n_zero_bad !== 0) begin failures++; $display("FAIL pad_zero_shifts: got %0d bad %0d expected 4 bad 0", n_zero, n_zero_bad); end
      checks++;
      if (n_conv_err !== 0 || n_cap_err !== 0) begin failures++; $display("FAIL full_conv_cap_timing: got %0d/%0d errors expected 0/0", n_conv_err, n_cap_err); end
      checks++;
      if (n_pool_err !== 0 || n_ov_err !== 0 || n_idx_err !== 0) begin
         failures++;
         $display("FAIL full_pool_out_timing: got %0d/%0d/%0d errors expected 0/0/0", n_pool_err, n_ov_err, n_idx_err);
      end
   endtask

   task automatic test_stall();
      bit ok;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      mon_strict = 1'b0;
      start_frame();
      repeat (40) tick();
      checks++;
      if (n_acc !== 14 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_accepts: got %0d ready=%0b expected 14 ready=0", n_acc, bus.in_ready); end
      checks++;
      if (n_pool !== 1 || bus.out_valid !== 1'b1 || bus.out_idx !== 7'd0) begin
         failures++;
         $display("FAIL stall_hold: got pool=%0d valid=%0b idx=%0d expected 1 1 0", n_pool, bus.out_valid, bus.out_idx);
      end
`ifdef CONV_POOL_SEQ_PERF_EN
      checks++;
      if (stall_cycles !== 16'(n_hold) || n_hold == 0) begin failures++; $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, n_hold); end
`endif
      bus.out_ready = 1'b1;
      wait_done(2000, 1'b0, ok);
      checks++;
      if (!ok || n_acc !== 500 || n_pool !== 100) begin failures++; $display("FAIL stall_resume: got done=%0b acc=%0d pool=%0d expected 1 500 100", ok, n_acc, n_pool); end
      checks++;
      if (n_out !== 100 || n_idx_err !== 0 || n_ov_err !== 0 || last_idx !== 7'd99) begin
         failures++;
         $display("FAIL stall_outputs: got out=%0d idx_err=%0d ov_err=%0d last=%0d expected 100 0 0 99", n_out, n_idx_err, n_ov_err, last_idx);
      end
      checks++;
      if (n_conv_err !== 0 || n_cap_err !== 0) begin failures++; $display("FAIL stall_conv_cap: got %0d/%0d errors expected 0/0", n_conv_err, n_cap_err); end
      repeat (2) tick();
   endtask

   task automatic test_abort();
      bit ok;
      logic [18:0] outs;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      mon_strict = 1'b1;
      start_frame();
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (n_acc >= 250) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok || n_done !== 0) begin failures++; $display("FAIL abort_reach_250: got reached=%0b done=%0d expected 1 0", ok, n_done); end
      rst = 1'b1;
      mon_clr = 1'b1;
      tick();
      outs = {busy, done, bus.in_ready, bus.win_shift, bus.win_zero, bus.conv_en, bus.relu_cap,
              bus.pool_slot, bus.pool_en, bus.out_valid, bus.out_idx};
      checks++;
      if (outs !== 19'd0) begin failures++; $display("FAIL abort_outputs: got %h expected 0", outs); end
      rst = 1'b0;
      tick();
      start_frame();
      wait_done(2000, 1'b0, ok);
      checks++;
      if (!ok || n_acc !== 500 || n_out !== 100 || n_done !== 1) begin
         failures++;
         $display("FAIL abort_rerun: got done=%0b acc=%0d out=%0d ndone=%0d expected 1 500 100 1", ok, n_acc, n_out, n_done);
      end
      checks++;
      if (n_conv_err !== 0 || n_cap_err !== 0 || n_pool_err !== 0 || n_idx_err !== 0) begin
         failures++;
         $display("FAIL abort_rerun_timing: got %0d/%0d/%0d/%0d errors expected all 0", n_conv_err, n_cap_err, n_pool_err, n_idx_err);
      end
      repeat (2) tick();
   endtask

   task automatic test_busy_start_toggle();
      bit ok;
      bit pulsed;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      mon_strict = 1'b1;
      pulsed = 1'b0;
      start_frame();
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         bus.in_valid = ~bus.in_valid;
         start = (n_acc == 100 && !pulsed);
         if (start) pulsed = 1'b1;
         if (n_done > 0) begin
            ok = 1'b1;
            break;
         end
      end
      start = 1'b0;
      repeat (3) tick();
      checks++;
      if (!ok || n_acc !== 500 || n_conv !== 500 || n_done !== 1) begin
         failures++;
         $display("FAIL toggle_counts: got done=%0b acc=%0d conv=%0d ndone=%0d expected 1 500 500 1", ok, n_acc, n_conv, n_done);
      end
      checks++;
      if (n_out !== 100 || last_idx !== 7'd99 || n_idx_err !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL toggle_outputs: got out=%0d last=%0d idx_err=%0d busy=%0b expected 100 99 0 0", n_out, last_idx, n_idx_err, busy);
      end
      checks++;
      if (n_conv_err !== 0 || n_cap_err !== 0 || n_pool_err !== 0 || n_ov_err !== 0) begin
         failures++;
         $display("FAIL toggle_timing: got %0d/%0d/%0d/%0d errors expected all 0", n_conv_err, n_cap_err, n_pool_err, n_ov_err);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_full_frame();
      test_stall();
      test_abort();
      test_busy_start_toggle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
